// File: rtl/alu_pkg.sv
// Shared op-code encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SRLV  = 4'b0100;
    localparam logic [3:0] OP_PASSA = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_SRAV  = 4'b1100;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StIter = 2'b01,
        StDone = 2'b10
    } state_e;

    // MULTU always iterates; DIVU iterates unless the divisor is zero.
    function automatic logic is_iter_op(input logic [3:0] op, input logic b_zero);
        return (op == OP_MULTU) || ((op == OP_DIVU) && !b_zero);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Single combinational step of the iterative MULTU / DIVU datapath.
// MULTU: acc is the running high half, shreg the multiplier shifting out into the low half.
// DIVU:  acc is the partial remainder, shreg the dividend shifting out / quotient shifting in.
module alu_mc_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_mode,    // 1: divide, 0: multiply
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shreg
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // One shift-add (multiply) or restoring subtract-shift (divide) step.
    always_comb begin
        w_sum     = {1'b0, i_acc} + (i_shreg[0] ? {1'b0, i_divisor} : {(WIDTH + 1){1'b0}});
        w_shifted = {i_acc, i_shreg[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, i_divisor};
        if (i_mode) begin
            // Top bit of w_diff is the borrow: set when the shifted remainder < divisor.
            if (!w_diff[WIDTH]) begin
                o_acc   = w_diff[WIDTH-1:0];
                o_shreg = {i_shreg[WIDTH-2:0], 1'b1};
            end else begin
                o_acc   = w_shifted[WIDTH-1:0];
                o_shreg = {i_shreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc   = w_sum[WIDTH:1];
            o_shreg = {w_sum[0], i_shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus iterative MULTU/DIVU.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_zout,
    output logic             o_nout,
    output logic             o_vout,
    output logic             o_dz
);

    localparam int unsigned CW = SHW + 1;

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [WIDTH-1:0] r_div, w_div_nxt;
    logic [WIDTH-1:0] r_lo, w_lo_nxt;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;
    logic             r_z, w_z_nxt;
    logic             r_n, w_n_nxt;
    logic             r_v, w_v_nxt;
    logic             r_dz, w_dz_nxt;

    logic [WIDTH-1:0] w_acc_step, w_shreg_step;
    logic [WIDTH-1:0] w_sum, w_diff;
    logic             w_v_add, w_v_sub;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_q_lo, w_q_hi;
    logic             w_q_z, w_q_n, w_q_v, w_q_dz, w_q_valid;
    logic             w_iter_op;

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .i_acc     (r_acc),
        .i_shreg   (r_shreg),
        .i_divisor (r_div),
        .i_mode    (r_mode),
        .o_acc     (w_acc_step),
        .o_shreg   (w_shreg_step)
    );

    assign w_sum     = i_a + i_b;
    assign w_diff    = i_a - i_b;
    assign w_v_add   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    assign w_v_sub   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    assign w_shamt   = i_a[SHW-1:0];
    assign w_iter_op = is_iter_op(i_op, (i_b == '0));

    // Single-cycle result mux, evaluated on the live operands at accept time.
    always_comb begin
        w_q_lo    = '0;
        w_q_hi    = '0;
        w_q_v     = 1'b0;
        w_q_dz    = 1'b0;
        w_q_valid = 1'b1;
        unique case (i_op)
            OP_AND:   w_q_lo = i_a & i_b;
            OP_OR:    w_q_lo = i_a | i_b;
            OP_ADD: begin
                w_q_lo = w_sum;
                w_q_v  = w_v_add;
            end
            OP_SUB: begin
                w_q_lo = w_diff;
                w_q_v  = w_v_sub;
            end
            // Sign of a-b corrected by overflow gives the true signed less-than.
            OP_SLT:   w_q_lo = {{(WIDTH - 1){1'b0}}, w_diff[WIDTH-1] ^ w_v_sub};
            OP_SRLV:  w_q_lo = i_b >> w_shamt;
            OP_SRAV:  w_q_lo = $unsigned($signed(i_b) >>> w_shamt);
            OP_PASSA: w_q_lo = i_a;
            // Only reached on this path when b == 0.
            OP_DIVU: begin
                w_q_lo = '1;
                w_q_hi = i_a;
                w_q_dz = 1'b1;
            end
            OP_MULTU: w_q_valid = 1'b1;
            default:  w_q_valid = 1'b0;
        endcase
        w_q_z = w_q_valid && (w_q_lo == '0);
        w_q_n = w_q_valid && w_q_lo[WIDTH-1];
    end

    // FSM next state, iteration registers and result capture on entry to DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_acc_nxt   = r_acc;
        w_shreg_nxt = r_shreg;
        w_div_nxt   = r_div;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_z_nxt     = r_z;
        w_n_nxt     = r_n;
        w_v_nxt     = r_v;
        w_dz_nxt    = r_dz;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    if (w_iter_op) begin
                        w_state_nxt = StIter;
                        w_cnt_nxt   = CW'(WIDTH);
                        w_mode_nxt  = (i_op == OP_DIVU);
                        w_acc_nxt   = '0;
                        w_shreg_nxt = i_a;
                        w_div_nxt   = i_b;
                    end else begin
                        w_state_nxt = StDone;
                        w_lo_nxt    = w_q_lo;
                        w_hi_nxt    = w_q_hi;
                        w_z_nxt     = w_q_z;
                        w_n_nxt     = w_q_n;
                        w_v_nxt     = w_q_v;
                        w_dz_nxt    = w_q_dz;
                    end
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StIter: begin
                w_acc_nxt   = w_acc_step;
                w_shreg_nxt = w_shreg_step;
                w_cnt_nxt   = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = StDone;
                    w_lo_nxt    = w_shreg_step;
                    w_hi_nxt    = w_acc_step;
                    w_z_nxt     = (w_shreg_step == '0);
                    w_n_nxt     = w_shreg_step[WIDTH-1];
                    w_v_nxt     = 1'b0;
                    w_dz_nxt    = 1'b0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_acc   <= '0;
            r_shreg <= '0;
            r_div   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_acc   <= w_acc_nxt;
            r_shreg <= w_shreg_nxt;
            r_div   <= w_div_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_z     <= w_z_nxt;
            r_n     <= w_n_nxt;
            r_v     <= w_v_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    assign o_ready = (r_state == StIdle) || (r_state == StDone);
    assign o_busy  = (r_state == StIter);
    assign o_done  = (r_state == StDone);
    assign o_lo    = r_lo;
    assign o_hi    = r_hi;
    assign o_zout  = r_z;
    assign o_nout  = r_n;
    assign o_vout  = r_v;
    assign o_dz    = r_dz;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH = 32.
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready, busy, done;
    logic [31:0] lo, hi;
    logic        zout, nout, vout, dz;

    int n_vec;
    int n_err;

    alu_mc #(
        .WIDTH (32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .o_ready (ready),
        .o_busy  (busy),
        .o_done  (done),
        .o_lo    (lo),
        .o_hi    (hi),
        .o_zout  (zout),
        .o_nout  (nout),
        .o_vout  (vout),
        .o_dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] e_lo, input logic [31:0] e_hi,
                             input logic e_z, input logic e_n, input logic e_v, input logic e_dz);
        check({tag, ".lo"}, lo, e_lo);
        check({tag, ".hi"}, hi, e_hi);
        check({tag, ".z"}, zout, e_z);
        check({tag, ".n"}, nout, e_n);
        check({tag, ".v"}, vout, e_v);
        check({tag, ".dz"}, dz, e_dz);
    endtask

    // Launch one op and wait (bounded) for done; poke re-drives start mid-iteration.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input int exp_lat, input int exp_busy,
                          input bit poke);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (poke && lat == 5) begin
                start = 1'b1;
                op    = 4'b0010;
                a     = 32'd1;
                b     = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busycycles"}, busy_cnt, exp_busy);
    endtask

    initial begin
        int done_seen;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'b0;
        a     = '0;
        b     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset.ready", ready, 1'b1);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.lo", lo, 32'h0);
        check("reset.hi", hi, 32'h0);

        run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 0, 1'b0);
        check_res("and", 32'h00F0_1200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("or", 4'b0001, 32'h8000_0001, 32'h0000_0100, 1, 0, 1'b0);
        check_res("or", 32'h8000_0101, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 0, 1'b0);
        check_res("add_ovf", 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Accepted straight out of DONE: done re-pulses the next cycle.
        run_op("add_b2b", 4'b0010, 32'h0000_0003, 32'h0000_0004, 1, 0, 1'b0);
        check_res("add_b2b", 32'h0000_0007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 0, 1'b0);
        check_res("sub_zero", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 1, 0, 1'b0);
        check_res("sub_ovf", 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        run_op("slt", 4'b0111, 32'h8000_0000, 32'h0000_0001, 1, 0, 1'b0);
        check_res("slt", 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("srav", 4'b1100, 32'd4, 32'hF000_0000, 1, 0, 1'b0);
        check_res("srav", 32'hFF00_0000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_op("srlv", 4'b0100, 32'd4, 32'hF000_0000, 1, 0, 1'b0);
        check_res("srlv", 32'h0F00_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("passa", 4'b0101, 32'hDEAD_BEEF, 32'h1, 1, 0, 1'b0);
        check_res("passa", 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        run_op("badop", 4'b0011, 32'h5, 32'h5, 1, 0, 1'b0);
        check_res("badop", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start re-asserted with new operands mid-ITER must be ignored.
        run_op("multu", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32, 1'b1);
        check_res("multu", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("multu.hold_lo", lo, 32'h0000_0001);
        check("multu.hold_hi", hi, 32'hFFFF_FFFE);
        check("multu.idle_done", done, 1'b0);

        run_op("divu", 4'b1001, 32'd100, 32'd7, 33, 32, 1'b0);
        check_res("divu", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("divu_dz", 4'b1001, 32'd9, 32'd0, 1, 0, 1'b0);
        check_res("divu_dz", 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset at ITER cycle 10 of a MULTU aborts it with no done.
        @(negedge clk);
        start = 1'b1;
        op    = 4'b1000;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("rst_mid.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.busy", busy, 1'b0);
        check("rst_mid.ready", ready, 1'b1);
        check("rst_mid.done", done, 1'b0);
        check_res("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("rst_mid.no_done", done_seen, 0);

        run_op("add_after_rst", 4'b0010, 32'd10, 32'd20, 1, 0, 1'b0);
        check_res("add_after_rst", 32'd30, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
